// File: rtl/axi_lite_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4-lite master port among NREQ native load/store requesters.
// Define AXI_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module axi_lite_rr_arbiter #(
  parameter int          NREQ      = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_we,
  input  logic [32*NREQ-1:0]   req_addr,
  input  logic [32*NREQ-1:0]   req_wdata,
  input  logic [4*NREQ-1:0]    req_wstrb,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic                 axi_awvalid,
  input  logic                 axi_awready,
  output logic [31:0]          axi_awaddr,
  output logic [2:0]           axi_awprot,
  output logic                 axi_wvalid,
  input  logic                 axi_wready,
  output logic [31:0]          axi_wdata,
  output logic [3:0]           axi_wstrb,
  input  logic                 axi_bvalid,
  output logic                 axi_bready,
  input  logic [1:0]           axi_bresp,
  output logic                 axi_arvalid,
  input  logic                 axi_arready,
  output logic [31:0]          axi_araddr,
  output logic [2:0]           axi_arprot,
  input  logic                 axi_rvalid,
  output logic                 axi_rready,
  input  logic [31:0]          axi_rdata,
  input  logic [1:0]           axi_rresp
);

  localparam int            IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW:0]   NREQ_W = (IW+1)'(NREQ);
  localparam logic [IW-1:0] LAST_W = IW'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_RADDR = 3'd2,
    S_WRESP = 3'd3,
    S_RRESP = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [31:0]     resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;

  logic [2*NREQ-1:0] rot2_s;
  logic [NREQ-1:0]   rot_s;
  logic [IW-1:0]     off_s;
  logic [IW:0]       sum_s;
  logic [IW:0]       sum_wrap_s;
  logic [IW-1:0]     grant_idx_s;
  logic              grant_found_s;
  logic [NREQ-1:0]   grant_oh_s;
  logic [NREQ-1:0]   req_ready_s;
  logic              unused_resp_lsb_s;

  assign unused_resp_lsb_s = axi_bresp[0] ^ axi_rresp[0];

  // Rotate requests so the rr pointer sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    rot2_s = {req_valid, req_valid} >> rr_q;
    rot_s  = rot2_s[NREQ-1:0];
    off_s  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      off_s = rot_s[k] ? IW'(k) : off_s;
    end
    sum_s         = {1'b0, rr_q} + {1'b0, off_s};
    sum_wrap_s    = (sum_s >= NREQ_W) ? (sum_s - NREQ_W) : sum_s;
    grant_idx_s   = sum_wrap_s[IW-1:0];
    grant_found_s = |req_valid;
    grant_oh_s    = grant_found_s ? (NREQ'(1) << grant_idx_s) : '0;
  end

  // Transaction FSM: next state, latched request payload and completion response.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    gnt_d        = gnt_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    resp_valid_d = '0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    req_ready_s  = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_found_s) begin
          req_ready_s = grant_oh_s;
          gnt_d       = grant_idx_s;
          addr_d      = BASE_ADDR + req_addr[{grant_idx_s, 5'd0} +: 32];
          wdata_d     = req_wdata[{grant_idx_s, 5'd0} +: 32];
          wstrb_d     = req_wstrb[{grant_idx_s, 2'd0} +: 4];
          if (req_we[grant_idx_s]) begin
            state_d   = S_WADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RADDR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WADDR: begin
        // AW and W complete independently; leave only once both have handshaken.
        awvalid_d = awvalid_q & ~axi_awready;
        wvalid_d  = wvalid_q & ~axi_wready;
        state_d   = (!awvalid_d && !wvalid_d) ? S_WRESP : S_WADDR;
      end
      S_RADDR: begin
        state_d = axi_arready ? S_RRESP : S_RADDR;
      end
      S_WRESP: begin
        if (axi_bvalid) begin
          resp_valid_d = NREQ'(1) << gnt_q;
          resp_rdata_d = 32'h0000_0000;
          resp_err_d   = axi_bresp[1];
          rr_d         = (gnt_q == LAST_W) ? '0 : gnt_q + IW'(1);
          state_d      = S_IDLE;
        end else begin
          state_d = S_WRESP;
        end
      end
      S_RRESP: begin
        if (axi_rvalid) begin
          resp_valid_d = NREQ'(1) << gnt_q;
          resp_rdata_d = axi_rdata;
          resp_err_d   = axi_rresp[1];
          rr_d         = (gnt_q == LAST_W) ? '0 : gnt_q + IW'(1);
          state_d      = S_IDLE;
        end else begin
          state_d = S_RRESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef AXI_ARB_FIXED_PRIO_EN
    rr_d = '0;
`endif
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_q         <= '0;
      gnt_q        <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      addr_q       <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      wstrb_q      <= 4'b0000;
      resp_valid_q <= '0;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      gnt_q        <= gnt_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Accept pulse comes straight from arbitration so the grant is seen in the same cycle.
  assign req_ready   = rst ? '0 : req_ready_s;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign axi_awvalid = awvalid_q;
  assign axi_awaddr  = addr_q;
  assign axi_awprot  = 3'b000;
  assign axi_wvalid  = wvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_bready  = (state_q == S_WRESP);
  assign axi_arvalid = (state_q == S_RADDR);
  assign axi_araddr  = addr_q;
  assign axi_arprot  = 3'b000;
  assign axi_rready  = (state_q == S_RRESP);

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed testbench for axi_lite_rr_arbiter; a second instance with a high base address checks address wrap.
module tb_axi_lite_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic [1:0]  req_ready, resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
  logic [2:0]  axi_awprot, axi_arprot;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic [1:0]  axi_bresp, axi_rresp;

  logic [1:0]  w_unused_req_ready, w_unused_resp_valid;
  logic [31:0] w_unused_resp_rdata, w_unused_awaddr, w_unused_wdata, w_araddr;
  logic        w_unused_resp_err, w_unused_awvalid, w_unused_wvalid, w_unused_bready;
  logic        w_unused_arvalid, w_unused_rready;
  logic [2:0]  w_unused_awprot, w_unused_arprot;
  logic [3:0]  w_unused_wstrb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi_lite_rr_arbiter #(.NREQ(2), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp)
  );

  axi_lite_rr_arbiter #(.NREQ(2), .BASE_ADDR(32'hFFFF_FFF0)) dut_wrap (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(w_unused_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(w_unused_resp_valid), .resp_rdata(w_unused_resp_rdata), .resp_err(w_unused_resp_err),
    .axi_awvalid(w_unused_awvalid), .axi_awready(axi_awready), .axi_awaddr(w_unused_awaddr), .axi_awprot(w_unused_awprot),
    .axi_wvalid(w_unused_wvalid), .axi_wready(axi_wready), .axi_wdata(w_unused_wdata), .axi_wstrb(w_unused_wstrb),
    .axi_bvalid(axi_bvalid), .axi_bready(w_unused_bready), .axi_bresp(axi_bresp),
    .axi_arvalid(w_unused_arvalid), .axi_arready(axi_arready), .axi_araddr(w_araddr), .axi_arprot(w_unused_arprot),
    .axi_rvalid(axi_rvalid), .axi_rready(w_unused_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp)
  );

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b00; req_we = 2'b00; req_addr = 64'h0; req_wdata = 64'h0; req_wstrb = 8'h00;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = 32'h0; axi_rresp = 2'b00;
    @(negedge clk); @(negedge clk);
    vectors++;
    if ({req_ready, resp_valid, resp_err} !== 5'b0 || resp_rdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_resp: ready=%b rv=%b err=%b rdata=%h, want all 0", req_ready, resp_valid, resp_err, resp_rdata);
    end
    vectors++;
    if ({axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready} !== 5'b0) begin
      miscompares++; $display("FAIL reset_axi: aw=%b w=%b b=%b ar=%b r=%b, want 0", axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    req_valid = 2'b01; req_we = 2'b00; req_addr = 64'h0000_0000_0000_0008; axi_arready = 1'b1; #1;
    vectors++;
    if (req_ready !== 2'b01) begin miscompares++; $display("FAIL read_grant: req_ready=%b want 01", req_ready); end
    @(negedge clk); req_valid = 2'b00;
    vectors++;
    if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h8 || axi_arprot !== 3'b000) begin
      miscompares++; $display("FAIL read_ar: arvalid=%b araddr=%h arprot=%b want 1 00000008 000", axi_arvalid, axi_araddr, axi_arprot);
    end
    @(negedge clk);
    vectors++;
    if (axi_rready !== 1'b1 || axi_arvalid !== 1'b0) begin
      miscompares++; $display("FAIL read_rready: rready=%b arvalid=%b want 1 0", axi_rready, axi_arvalid);
    end
    axi_rvalid = 1'b1; axi_rdata = 32'hA5A5_0001; axi_rresp = 2'b00;
    @(negedge clk);
    vectors++;
    if (resp_valid !== 2'b01 || resp_rdata !== 32'hA5A5_0001 || resp_err !== 1'b0) begin
      miscompares++; $display("FAIL read_resp: rv=%b rdata=%h err=%b want 01 a5a50001 0", resp_valid, resp_rdata, resp_err);
    end
    axi_rvalid = 1'b0; axi_arready = 1'b0;
    @(negedge clk);
    vectors++;
    if (resp_valid !== 2'b00 || resp_rdata !== 32'hA5A5_0001) begin
      miscompares++; $display("FAIL read_hold: rv=%b rdata=%h want 00 a5a50001", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_write_skewed();
    @(negedge clk);
    req_valid = 2'b10; req_we = 2'b10; req_addr = 64'h0000_0040_0000_0000;
    req_wdata = 64'h1234_5678_0000_0000; req_wstrb = 8'h30; axi_awready = 1'b1; axi_wready = 1'b0; #1;
    vectors++;
    if (req_ready !== 2'b10) begin miscompares++; $display("FAIL write_grant: req_ready=%b want 10", req_ready); end
    @(negedge clk); req_valid = 2'b00;
    vectors++;
    if (axi_awvalid !== 1'b1 || axi_wvalid !== 1'b1 || axi_awaddr !== 32'h40 || axi_awprot !== 3'b000) begin
      miscompares++; $display("FAIL write_aw: awvalid=%b wvalid=%b awaddr=%h awprot=%b want 1 1 00000040 000", axi_awvalid, axi_wvalid, axi_awaddr, axi_awprot);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); axi_awready = 1'b0;
      vectors++;
      if (axi_awvalid !== 1'b0 || axi_wvalid !== 1'b1 || axi_wdata !== 32'h1234_5678 || axi_wstrb !== 4'b0011) begin
        miscompares++; $display("FAIL write_w_hold: awvalid=%b wvalid=%b wdata=%h wstrb=%b want 0 1 12345678 0011", axi_awvalid, axi_wvalid, axi_wdata, axi_wstrb);
      end
    end
    axi_wready = 1'b1;
    @(negedge clk); axi_wready = 1'b0;
    vectors++;
    if (axi_wvalid !== 1'b0 || axi_bready !== 1'b1) begin
      miscompares++; $display("FAIL write_bready: wvalid=%b bready=%b want 0 1", axi_wvalid, axi_bready);
    end
    axi_bvalid = 1'b1; axi_bresp = 2'b10;
    @(negedge clk); axi_bvalid = 1'b0; axi_bresp = 2'b00;
    vectors++;
    if (resp_valid !== 2'b10 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
      miscompares++; $display("FAIL write_resp: rv=%b err=%b rdata=%h want 10 1 00000000", resp_valid, resp_err, resp_rdata);
    end
  endtask

  task automatic test_contention();
    logic [1:0] got [4];
    logic [1:0] exp_g [4];
    int ngrant = 0;
`ifdef AXI_ARB_FIXED_PRIO_EN
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    for (int i = 0; i < 4; i++) got[i] = 2'b00;
    @(negedge clk);
    req_valid = 2'b11; req_we = 2'b00; req_addr = 64'h0000_0200_0000_0100;
    axi_arready = 1'b1; axi_rvalid = 1'b1; axi_rdata = 32'h0; axi_rresp = 2'b00;
    for (int cyc = 0; cyc < 40 && ngrant < 4; cyc++) begin
      #1;
      if (req_ready !== 2'b00) begin got[ngrant] = req_ready; ngrant++; end
      @(negedge clk);
    end
    req_valid = 2'b00;
    vectors++;
    if (ngrant != 4) begin miscompares++; $display("FAIL contention_timeout: grants=%0d want 4", ngrant); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got[i] !== exp_g[i]) begin miscompares++; $display("FAIL contention_grant%0d: req_ready=%b want %b", i, got[i], exp_g[i]); end
    end
    repeat (3) @(negedge clk);
    axi_arready = 1'b0; axi_rvalid = 1'b0;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req_valid = 2'b11; req_we = 2'b00; req_addr = 64'h0000_0020_0000_0030; axi_arready = 1'b0; #1;
    vectors++;
    if (req_ready !== 2'b01) begin miscompares++; $display("FAIL bp_grant: req_ready=%b want 01", req_ready); end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) req_valid = 2'b10;
      #1;
      vectors++;
      if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h30 || req_ready !== 2'b00) begin
        miscompares++; $display("FAIL bp_stall%0d: arvalid=%b araddr=%h req_ready=%b want 1 00000030 00", i, axi_arvalid, axi_araddr, req_ready);
      end
    end
    axi_arready = 1'b1;
    @(negedge clk); axi_arready = 1'b0; axi_rvalid = 1'b1; axi_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    vectors++;
    if (resp_valid !== 2'b01 || resp_rdata !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL bp_resp: rv=%b rdata=%h want 01 deadbeef", resp_valid, resp_rdata);
    end
    axi_rvalid = 1'b0; axi_arready = 1'b1; #1;
    vectors++;
    if (req_ready !== 2'b10) begin miscompares++; $display("FAIL bp_next_grant: req_ready=%b want 10", req_ready); end
    @(negedge clk); req_valid = 2'b00;
    vectors++;
    if (axi_araddr !== 32'h20 || w_araddr !== 32'h0000_0010) begin
      miscompares++; $display("FAIL wrap_araddr: araddr=%h wrap_araddr=%h want 00000020 00000010", axi_araddr, w_araddr);
    end
    @(negedge clk); axi_rvalid = 1'b1; axi_rdata = 32'h0000_0055;
    @(negedge clk);
    vectors++;
    if (resp_valid !== 2'b10 || resp_rdata !== 32'h0000_0055) begin
      miscompares++; $display("FAIL bp_resp2: rv=%b rdata=%h want 10 00000055", resp_valid, resp_rdata);
    end
    axi_rvalid = 1'b0; axi_arready = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    req_valid = 2'b01; req_we = 2'b00; req_addr = 64'h0; axi_arready = 1'b1;
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); axi_rvalid = 1'b1; axi_rdata = 32'h0000_0007;
    @(negedge clk);
    axi_rvalid = 1'b0; axi_arready = 1'b0;
    req_valid = 2'b01; req_we = 2'b01; req_addr = 64'h4; req_wdata = 64'hCAFE_0000; req_wstrb = 8'h0F;
    axi_awready = 1'b1; axi_wready = 1'b1; #1;
    vectors++;
    if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rst_write_grant: req_ready=%b want 01", req_ready); end
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk);
    vectors++;
    if (axi_bready !== 1'b1 || axi_awvalid !== 1'b0 || axi_wvalid !== 1'b0) begin
      miscompares++; $display("FAIL rst_in_wresp: bready=%b awvalid=%b wvalid=%b want 1 0 0", axi_bready, axi_awvalid, axi_wvalid);
    end
    rst = 1'b1; axi_awready = 1'b0; axi_wready = 1'b0;
    @(negedge clk);
    vectors++;
    if ({req_ready, resp_valid, resp_err, axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready} !== 10'b0 || resp_rdata !== 32'h0) begin
      miscompares++; $display("FAIL rst_mid_outputs: ready=%b rv=%b err=%b rdata=%h bready=%b want all 0", req_ready, resp_valid, resp_err, resp_rdata, axi_bready);
    end
    rst = 1'b0; axi_bvalid = 1'b1; axi_bresp = 2'b00;
    req_valid = 2'b11; req_we = 2'b00; req_addr = 64'h0000_0008_0000_0004; axi_arready = 1'b1; #1;
    vectors++;
    if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rst_rr_cleared: req_ready=%b want 01", req_ready); end
    @(negedge clk); req_valid = 2'b00; axi_bvalid = 1'b0;
    vectors++;
    if (resp_valid !== 2'b00 || axi_arvalid !== 1'b1 || axi_araddr !== 32'h4) begin
      miscompares++; $display("FAIL rst_restart: rv=%b arvalid=%b araddr=%h want 00 1 00000004", resp_valid, axi_arvalid, axi_araddr);
    end
    @(negedge clk); axi_rvalid = 1'b1; axi_rdata = 32'h0000_0011;
    @(negedge clk);
    vectors++;
    if (resp_valid !== 2'b01 || resp_rdata !== 32'h0000_0011) begin
      miscompares++; $display("FAIL rst_restart_resp: rv=%b rdata=%h want 01 00000011", resp_valid, resp_rdata);
    end
    axi_rvalid = 1'b0; axi_arready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_skewed();
    test_contention();
    test_backpressure();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
